// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line
// against sys_clk, and flags a stuck line when rising edges stop arriving.
module pwm_capture #(
   parameter int              CNT_W       = 16,
   parameter logic [CNT_W-1:0] TIMEOUT_MAX = 16'd50_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             stuck_out,
   output logic             level_out
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_STUCK   = 2'd2
   } state_t;

   state_t           state_r;
   logic             s1_r;
   logic             s2_r;
   logic             p_r;
   logic             rise_s;
   logic [CNT_W-1:0] pcnt_r;
   logic [CNT_W-1:0] hcnt_r;

   // s2 is the only internal view of the line; p holds its previous value
   assign rise_s = s2_r & ~p_r;

   // Two-flop synchronizer plus the delay flop used for edge detection
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         p_r  <= 1'b0;
      end else begin
         s1_r <= pwm_in;
         s2_r <= s1_r;
         p_r  <= s2_r;
      end
   end

   // Period and high-time counters: restart at 1 on a rise, saturate at TIMEOUT_MAX
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pcnt_r <= '0;
         hcnt_r <= '0;
      end else if (rise_s) begin
         pcnt_r <= CNT_ONE;
         hcnt_r <= CNT_ONE;
      end else begin
         if (pcnt_r < TIMEOUT_MAX) begin
            pcnt_r <= pcnt_r + CNT_ONE;
         end else begin
            pcnt_r <= pcnt_r;
         end
         if (s2_r && (hcnt_r < TIMEOUT_MAX)) begin
            hcnt_r <= hcnt_r + CNT_ONE;
         end else begin
            hcnt_r <= hcnt_r;
         end
      end
   end

   // Measurement FSM with registered result, strobe and stuck outputs
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r    <= ST_IDLE;
         period_out <= '0;
         high_out   <= '0;
         meas_valid <= 1'b0;
         stuck_out  <= 1'b0;
         level_out  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // the first edge only starts a measurement window
               if (rise_s) begin
                  state_r <= ST_MEASURE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MEASURE: begin
               // a rise coinciding with the timeout still counts as a period
               if (rise_s) begin
                  period_out <= pcnt_r;
                  high_out   <= hcnt_r;
                  meas_valid <= 1'b1;
                  state_r    <= ST_MEASURE;
               end else if (pcnt_r == TIMEOUT_MAX) begin
                  state_r   <= ST_STUCK;
                  stuck_out <= 1'b1;
                  level_out <= s2_r;
               end else begin
                  state_r <= ST_MEASURE;
               end
            end
            ST_STUCK: begin
               // recovery edge re-arms without reporting a bogus period
               if (rise_s) begin
                  state_r   <= ST_MEASURE;
                  stuck_out <= 1'b0;
               end else begin
                  state_r <= ST_STUCK;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               stuck_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed PWM stimulus; a sample-level
// reference model predicts strobes, held results and stuck flags.
module tb_pwm_capture;

   localparam int          CNT_W = 16;
   localparam int          TI    = 20;
   localparam logic [15:0] TMAX  = 16'd20;
   localparam int          LV_N  = 8192;

   logic             sys_clk;
   logic             sys_rst;
   logic             pwm_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             meas_valid;
   logic             stuck_out;
   logic             level_out;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_MAX(TMAX)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .pwm_in     (pwm_in),
      .period_out (period_out),
      .high_out   (high_out),
      .meas_valid (meas_valid),
      .stuck_out  (stuck_out),
      .level_out  (level_out)
   );

   typedef struct {
      int edge_no;
      int period;
      int high;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   bit   chk_en = 1'b0;
   bit   lv [0:LV_N-1];

   bit   m_armed = 1'b0;
   bit   m_stuck = 1'b0;
   int   m_kprev = 0;
   int   exp_period = 0;
   int   exp_high = 0;
   int   exp_stuck = 0;
   int   exp_level = 0;

   // clock
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // reference model: records the level seen at each edge and applies the
   // period / high / timeout rules to the sampled sequence, two edges late
   initial begin
      int n;
      int k;
      int ones;
      bit rise;
      forever begin
         @(posedge sys_clk);
         edge_n++;
         n = edge_n;
         if (n >= LV_N) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", n, LV_N);
            $fatal(1, "cycle budget exhausted");
         end
         lv[n] = sys_rst ? 1'b0 : pwm_in;
         if (sys_rst) begin
            lv[n-1]    = 1'b0;
            m_armed    = 1'b0;
            m_stuck    = 1'b0;
            exp_period = 0;
            exp_high   = 0;
            exp_stuck  = 0;
            exp_level  = 0;
         end else if (n >= 3) begin
            k    = n - 2;
            rise = lv[k] && !lv[k-1];
            if (rise) begin
               if (m_armed && !m_stuck) begin
                  ones = 0;
                  for (int j = m_kprev; j < k; j++) ones += int'(lv[j]);
                  if (ones > TI) ones = TI;
                  sb_q.push_back('{n, k - m_kprev, ones});
                  exp_period = k - m_kprev;
                  exp_high   = ones;
               end
               m_stuck   = 1'b0;
               exp_stuck = 0;
               m_armed   = 1'b1;
               m_kprev   = k;
            end else if (m_armed && !m_stuck && (k - m_kprev) == TI) begin
               m_stuck   = 1'b1;
               exp_stuck = 1;
               exp_level = int'(lv[k]);
            end
         end
      end
   end

   // monitor: pops the scoreboard on every strobe and checks held outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (chk_en) begin
            while (sb_q.size() > 0 && sb_q[0].edge_no < edge_n) begin
               e = sb_q.pop_front();
               checks++;
               errors++;
               $display("FAIL missed_strobe: got none expected period %0d high %0d at edge %0d",
                        e.period, e.high, e.edge_no);
            end
            if (meas_valid) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe: got period %0d high %0d expected no strobe (edge %0d)",
                           period_out, high_out, edge_n);
               end else begin
                  e = sb_q.pop_front();
                  check("strobe_edge", edge_n, e.edge_no);
                  check("strobe_period", int'(period_out), e.period);
                  check("strobe_high", int'(high_out), e.high);
               end
            end
            check("held_period", int'(period_out), exp_period);
            check("held_high", int'(high_out), exp_high);
            check("stuck_out", int'(stuck_out), exp_stuck);
            check("level_out", int'(level_out), exp_level);
         end
      end
   end

   task automatic hold(input int cycles);
      repeat (cycles) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      pwm_in = 1'b1;
      hold(hi);
      pwm_in = 1'b0;
      hold(lo);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      hold(1);
      sys_rst = 1'b0;
   endtask

   // stimulus: directed scenarios followed by randomized pulse trains
   initial begin
      int r;
      int hi;
      int lo;
      sys_rst = 1'b1;
      pwm_in  = 1'b0;
      hold(3);
      sys_rst = 1'b0;
      chk_en  = 1'b1;

      // 10-cycle period, 3 high
      repeat (5) pulse(3, 7);
      // minimum period
      repeat (8) pulse(1, 1);
      // duty step 3 -> 7
      repeat (3) pulse(3, 7);
      repeat (3) pulse(7, 3);
      // stuck low then recovery
      repeat (2) pulse(3, 7);
      pwm_in = 1'b0;
      hold(25);
      repeat (4) pulse(3, 7);
      // stuck high then recovery
      pwm_in = 1'b1;
      hold(25);
      pwm_in = 1'b0;
      hold(3);
      repeat (3) pulse(3, 7);
      // period of exactly TIMEOUT_MAX
      repeat (3) pulse(5, 15);
      // reset mid-period
      repeat (2) pulse(3, 7);
      pulse(2, 3);
      do_reset();
      hold(2);
      repeat (3) pulse(3, 7);

      // randomized trains with occasional long gaps, stuck-high and resets
      repeat (60) begin
         r  = $urandom_range(0, 9);
         hi = $urandom_range(1, 10);
         lo = $urandom_range(1, 10);
         if (r == 0) begin
            do_reset();
         end else if (r == 1) begin
            lo = $urandom_range(15, 30);
         end else if (r == 2) begin
            hi = $urandom_range(15, 30);
         end
         pulse(hi, lo);
      end

      pwm_in = 1'b0;
      hold(30);
      chk_en = 1'b0;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
